// File: rtl/risc_mem_rd_arbiter.sv
// Two-port round-robin arbiter for the single memory read port (fetch = id 0, load = id 1).
// One read is outstanding at a time, and a watchdog turns a missing memory ack into an error completion.
module risc_mem_rd_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] f_rd_addr,
    input  logic              f_rd_addr_valid,
    output logic [DATA_W-1:0] f_rd_data,
    output logic              f_rd_ack,
    input  logic [ADDR_W-1:0] l_rd_addr,
    input  logic              l_rd_addr_valid,
    output logic [DATA_W-1:0] l_rd_data,
    output logic              l_rd_ack,
    output logic              rd_err,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_addr_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_ack,
    output logic              busy,
    output logic              grant_id
);

    localparam int               CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit               WD_EN    = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_id_q, grant_id_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_valid_q, mem_valid_d;
    logic [DATA_W-1:0] f_data_q, f_data_d;
    logic              f_ack_q, f_ack_d;
    logic [DATA_W-1:0] l_data_q, l_data_d;
    logic              l_ack_q, l_ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              winner;

    // last_grant resets to load so that fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_valid_q  <= 1'b0;
            f_data_q     <= '0;
            f_ack_q      <= 1'b0;
            l_data_q     <= '0;
            l_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            mem_addr_q   <= mem_addr_d;
            mem_valid_q  <= mem_valid_d;
            f_data_q     <= f_data_d;
            f_ack_q      <= f_ack_d;
            l_data_q     <= l_data_d;
            l_ack_q      <= l_ack_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        mem_addr_d   = mem_addr_q;
        mem_valid_d  = mem_valid_q;
        f_data_d     = '0;
        f_ack_d      = 1'b0;
        l_data_d     = '0;
        l_ack_d      = 1'b0;
        err_d        = 1'b0;
        winner       = 1'b0;

        case (state_q)
            IDLE: begin
                if (f_rd_addr_valid || l_rd_addr_valid) begin
                    if (f_rd_addr_valid && l_rd_addr_valid) begin
                        winner = ~last_grant_q;
                    end else begin
                        winner = l_rd_addr_valid;
                    end
                    mem_addr_d   = winner ? l_rd_addr : f_rd_addr;
                    mem_valid_d  = 1'b1;
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    cnt_d        = '0;
                    state_d      = BUSY;
                end
            end

            BUSY: begin
                if (mem_rd_ack) begin
                    mem_valid_d = 1'b0;
                    if (grant_id_q) begin
                        l_data_d = mem_rd_data;
                        l_ack_d  = 1'b1;
                    end else begin
                        f_data_d = mem_rd_data;
                        f_ack_d  = 1'b1;
                    end
                    state_d = RESP;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    // Error completion: data is left at zero and rd_err rides along with the ack.
                    mem_valid_d = 1'b0;
                    err_d       = 1'b1;
                    if (grant_id_q) begin
                        l_ack_d = 1'b1;
                    end else begin
                        f_ack_d = 1'b1;
                    end
                    state_d = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign f_rd_data         = f_data_q;
    assign f_rd_ack          = f_ack_q;
    assign l_rd_data         = l_data_q;
    assign l_rd_ack          = l_ack_q;
    assign rd_err            = err_q;
    assign mem_rd_addr       = mem_addr_q;
    assign mem_rd_addr_valid = mem_valid_q;
    assign busy              = busy_q;
    assign grant_id          = grant_id_q;

endmodule

// File: tb/tb_risc_mem_rd_arbiter.sv
// Self-checking bench for risc_mem_rd_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of round-robin grants, ack latency and watchdog expiry.
module tb_risc_mem_rd_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int TB_TIMEOUT = 4;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] f_rd_addr;
    logic              f_rd_addr_valid;
    logic [DATA_W-1:0] f_rd_data;
    logic              f_rd_ack;
    logic [ADDR_W-1:0] l_rd_addr;
    logic              l_rd_addr_valid;
    logic [DATA_W-1:0] l_rd_data;
    logic              l_rd_ack;
    logic              rd_err;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_addr_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_ack;
    logic              busy;
    logic              grant_id;

    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;
    logic rrLast;
    logic shownGrant;

    risc_mem_rd_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .f_rd_addr        (f_rd_addr),
        .f_rd_addr_valid  (f_rd_addr_valid),
        .f_rd_data        (f_rd_data),
        .f_rd_ack         (f_rd_ack),
        .l_rd_addr        (l_rd_addr),
        .l_rd_addr_valid  (l_rd_addr_valid),
        .l_rd_data        (l_rd_data),
        .l_rd_ack         (l_rd_ack),
        .rd_err           (rd_err),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_addr_valid(mem_rd_addr_valid),
        .mem_rd_data      (mem_rd_data),
        .mem_rd_ack       (mem_rd_ack),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "[TB] global time limit expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, ".mem_valid"}, 32'(mem_rd_addr_valid), 32'd0);
        checkOutput({tag, ".mem_addr"}, mem_rd_addr, 32'd0);
        checkOutput({tag, ".f_ack"}, 32'(f_rd_ack), 32'd0);
        checkOutput({tag, ".f_data"}, f_rd_data, 32'd0);
        checkOutput({tag, ".l_ack"}, 32'(l_rd_ack), 32'd0);
        checkOutput({tag, ".l_data"}, l_rd_data, 32'd0);
        checkOutput({tag, ".rd_err"}, 32'(rd_err), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".grant_id"}, 32'(grant_id), 32'd0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".mem_valid"}, 32'(mem_rd_addr_valid), 32'd0);
        checkOutput({tag, ".acks_err"}, 32'({f_rd_ack, l_rd_ack, rd_err}), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".grant_id"}, 32'(grant_id), 32'(shownGrant));
    endtask

    task automatic applyReset();
        reset           = 1'b1;
        f_rd_addr_valid = 1'b0;
        l_rd_addr_valid = 1'b0;
        f_rd_addr       = '0;
        l_rd_addr       = '0;
        mem_rd_ack      = 1'b0;
        mem_rd_data     = '0;
        @(negedge clk);
        @(negedge clk);
        checkZero("reset");
        reset      = 1'b0;
        rrLast     = 1'b1;
        shownGrant = 1'b0;
    endtask

    // One idle cycle with no requests pending; an optional stray memory ack must change nothing.
    task automatic idleCycle(input bit spurious);
        mem_rd_ack  = spurious;
        mem_rd_data = $urandom;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        checkIdle("idle");
    endtask

    // Called at the falling edge of an IDLE cycle with at least one request raised.
    // The memory acks ackDelay cycles after the request appears; a delay of TB_TIMEOUT or more never acks.
    task automatic applyStimulus(input int ackDelay, input logic [31:0] memData, input bit churn, input bit lateAck);
        logic        winner;
        logic [31:0] expAddr;
        bit          timedOut;
        int          doneCycle;

        if (f_rd_addr_valid && l_rd_addr_valid) winner = ~rrLast;
        else                                    winner = l_rd_addr_valid;
        expAddr   = winner ? l_rd_addr : f_rd_addr;
        timedOut  = (ackDelay >= TB_TIMEOUT);
        doneCycle = timedOut ? TB_TIMEOUT : ackDelay + 1;

        for (int cyc = 1; cyc <= doneCycle; cyc++) begin
            @(negedge clk);
            checkOutput("busy.mem_valid", 32'(mem_rd_addr_valid), 32'd1);
            checkOutput("busy.mem_addr", mem_rd_addr, expAddr);
            checkOutput("busy.grant_id", 32'(grant_id), 32'(winner));
            checkOutput("busy.acks_err", 32'({f_rd_ack, l_rd_ack, rd_err}), 32'd0);
            checkOutput("busy.busy", 32'(busy), 32'd1);
            checkOutput("busy.other_data", winner ? f_rd_data : l_rd_data, 32'd0);
            mem_rd_ack  = (!timedOut && cyc == ackDelay + 1);
            mem_rd_data = mem_rd_ack ? memData : $urandom;
            if (churn) begin
                f_rd_addr       = $urandom;
                l_rd_addr       = $urandom;
                f_rd_addr_valid = 1'b1;
                l_rd_addr_valid = 1'b1;
            end
        end

        @(negedge clk);
        checkOutput("resp.f_ack", 32'(f_rd_ack), 32'(winner == 1'b0));
        checkOutput("resp.l_ack", 32'(l_rd_ack), 32'(winner == 1'b1));
        checkOutput("resp.f_data", f_rd_data, (winner == 1'b0 && !timedOut) ? memData : 32'd0);
        checkOutput("resp.l_data", l_rd_data, (winner == 1'b1 && !timedOut) ? memData : 32'd0);
        checkOutput("resp.rd_err", 32'(rd_err), 32'(timedOut));
        checkOutput("resp.mem_valid", 32'(mem_rd_addr_valid), 32'd0);
        checkOutput("resp.busy", 32'(busy), 32'd1);
        mem_rd_ack  = lateAck;
        mem_rd_data = $urandom;
        if (winner) l_rd_addr_valid = 1'b0;
        else        f_rd_addr_valid = 1'b0;
        rrLast     = winner;
        shownGrant = winner;

        @(negedge clk);
        mem_rd_ack = 1'b0;
        checkIdle("post");
    endtask

    initial begin
        applyReset();

        $display("[TB] fetch only");
        f_rd_addr       = 32'h10;
        f_rd_addr_valid = 1'b1;
        applyStimulus(2, 32'hDEADBEEF, 1'b0, 1'b0);
        idleCycle(1'b0);

        $display("[TB] simultaneous requests after reset");
        applyReset();
        f_rd_addr       = 32'h100;
        l_rd_addr       = 32'h200;
        f_rd_addr_valid = 1'b1;
        l_rd_addr_valid = 1'b1;
        applyStimulus(1, $urandom, 1'b0, 1'b0);
        applyStimulus(1, $urandom, 1'b0, 1'b0);
        f_rd_addr_valid = 1'b1;
        l_rd_addr_valid = 1'b1;
        applyStimulus(1, $urandom, 1'b0, 1'b0);
        applyStimulus(1, $urandom, 1'b0, 1'b0);

        $display("[TB] ack with request, back-to-back issue");
        f_rd_addr_valid = 1'b1;
        l_rd_addr_valid = 1'b1;
        applyStimulus(0, $urandom, 1'b0, 1'b0);
        applyStimulus(0, $urandom, 1'b0, 1'b0);

        $display("[TB] watchdog expiry and late ack");
        f_rd_addr       = 32'h7000;
        f_rd_addr_valid = 1'b1;
        applyStimulus(TB_TIMEOUT + 5, $urandom, 1'b0, 1'b0);
        idleCycle(1'b0);
        idleCycle(1'b1);
        idleCycle(1'b0);

        $display("[TB] reset during load transaction");
        l_rd_addr       = 32'hABC;
        l_rd_addr_valid = 1'b1;
        @(negedge clk);
        checkOutput("rstmid.mem_valid", 32'(mem_rd_addr_valid), 32'd1);
        checkOutput("rstmid.mem_addr", mem_rd_addr, 32'hABC);
        checkOutput("rstmid.grant_id", 32'(grant_id), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkZero("rstmid");
        reset           = 1'b0;
        l_rd_addr_valid = 1'b0;
        rrLast          = 1'b1;
        shownGrant      = 1'b0;
        mem_rd_ack      = 1'b1;
        mem_rd_data     = 32'h5555AAAA;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        checkOutput("rstmid.l_ack", 32'(l_rd_ack), 32'd0);
        checkIdle("rstmid.after");
        f_rd_addr       = 32'h44;
        f_rd_addr_valid = 1'b1;
        applyStimulus(1, 32'h12345678, 1'b0, 1'b0);

        $display("[TB] address churn");
        f_rd_addr       = 32'h500;
        f_rd_addr_valid = 1'b1;
        applyStimulus(3, $urandom, 1'b1, 1'b0);
        applyStimulus(2, $urandom, 1'b1, 1'b1);
        while (f_rd_addr_valid || l_rd_addr_valid) begin
            applyStimulus(1, $urandom, 1'b0, 1'b0);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 200; i++) begin
            if (!f_rd_addr_valid && $urandom_range(0, 2) == 0) begin
                f_rd_addr_valid = 1'b1;
                f_rd_addr       = $urandom;
            end
            if (!l_rd_addr_valid && $urandom_range(0, 2) == 0) begin
                l_rd_addr_valid = 1'b1;
                l_rd_addr       = $urandom;
            end
            if (f_rd_addr_valid || l_rd_addr_valid) begin
                applyStimulus($urandom_range(0, TB_TIMEOUT + 1), $urandom,
                              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            end else begin
                idleCycle(1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
